// File: rtl/cntlz_seq.sv
// Multi-cycle leading-zero / leading-one counter for wide operands.
// Scans 32 bits per cycle, most-significant chunk first, and stops at the first non-zero chunk.
module cntlz_seq #(
  parameter  int W  = 128,
  localparam int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [W-1:0]  i_data,
  input  logic          i_ones,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [CW-1:0] o_cnt,
  output logic          busy
);

  localparam int NCH = W / 32;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  sreg, sreg_n;
  logic [CW-1:0] acc, acc_n;
  logic [IW-1:0] idx, idx_n;
  logic [31:0]   top;
  logic [5:0]    z;

  assign top = sreg[W-1 -: 32];

  // Lowest-to-highest sweep: the last hit is the most significant set bit.
  always_comb begin
    z = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (top[i]) z = 6'(31 - i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      acc   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      acc   <= acc_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    acc_n   = acc;
    idx_n   = idx;
    if (ce) begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            // Leading ones become leading zeros, so one counter serves both modes.
            sreg_n  = i_ones ? ~i_data : i_data;
            acc_n   = '0;
            idx_n   = '0;
            state_n = SCAN;
          end
        end
        SCAN: begin
          acc_n = acc + CW'(z);
          if (z != 6'd32 || idx == IW'(NCH - 1)) begin
            state_n = DONE;
          end else begin
            sreg_n = sreg << 32;
            idx_n  = idx + IW'(1);
          end
        end
        DONE: begin
          if (o_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign i_ready = (state == IDLE) & ce;
  assign o_valid = (state == DONE) & ce;
  assign o_cnt   = acc;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_cntlz_seq.sv
// Scoreboard bench for cntlz_seq: driver pushes modelled results, monitor pops on each result transfer.
module tb_cntlz_seq;

  localparam int W   = 128;
  localparam int CW  = $clog2(W) + 1;
  localparam int NCH = W / 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [W-1:0]  i_data = '0;
  logic          i_ones = 1'b0;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic [CW-1:0] o_cnt;
  logic          busy;

  cntlz_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_ones(i_ones),
    .o_valid(o_valid), .o_ready(o_ready), .o_cnt(o_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rise = 0;
  logic prev_v = 1'b0;
  int   rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #3;
    case (rdy_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = 1'b0;
      default: o_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Reference: count leading zeros of the (optionally inverted) operand bit by bit.
  function automatic exp_t model(input logic [W-1:0] d, input logic ones, input int stall);
    exp_t e;
    logic [W-1:0] v;
    int n;
    v = ones ? ~d : d;
    n = 0;
    while (n < W && !v[W-1-n]) n++;
    e.cnt = n;
    e.lat = ((n == W) ? NCH : (n / 32 + 1)) + stall;
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (o_valid && !prev_v) rise = cyc;
      prev_v = o_valid;
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stale_result: got cnt %0d expected no result", o_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("o_cnt", int'(o_cnt), e.cnt);
          chk("latency", rise - e.acc, e.lat);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [W-1:0] d, input logic ones, input int stall);
    exp_t e;
    int n;
    step();
    i_valid = 1'b1;
    i_data  = d;
    i_ones  = ones;
    n = 0;
    @(negedge clk);
    while (!i_ready) begin
      n++;
      if (n > 200) begin
        timeout("accept");
        i_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e = model(d, ones, stall);
    e.acc = cyc + 1;
    sb.push_back(e);
    step();
    i_valid = 1'b0;
    i_data  = rnd_w();
    i_ones  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!o_valid) begin
      n++;
      if (n > 100) begin
        timeout("o_valid");
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        timeout("drain");
        sb.delete();
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset o_valid", int'(o_valid), 0);
    chk("reset i_ready", int'(i_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset o_cnt", int'(o_cnt), 0);

    // Single LSB set: full-length scan, then ready returns the cycle after transfer.
    issue(128'h1, 1'b0, 0);
    wait_valid();
    @(negedge clk);
    chk("i_ready after transfer", int'(i_ready), 1);
    chk("o_valid after transfer", int'(o_valid), 0);
    drain();

    issue(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 0);
    issue('0, 1'b0, 0);
    issue('1, 1'b1, 0);
    issue(128'hFFFF_FFFF_FFF0_0000_0000_0000_0000_0000, 1'b1, 0);
    issue(128'hFFFF_FFFF_FFF0_0000_0000_0000_0000_0000, 1'b0, 0);
    drain();

    // Back-pressure: result must hold while the request side is toggled.
    rdy_mode = 1;
    issue(128'h0000_0000_0000_0000_0010_0000_0000_0000, 1'b0, 0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      step();
      i_valid = 1'($urandom_range(0, 1));
      i_data  = rnd_w();
      @(negedge clk);
      chk("hold o_valid", int'(o_valid), 1);
      chk("hold o_cnt", int'(o_cnt), 75);
      chk("hold i_ready", int'(i_ready), 0);
    end
    step();
    i_valid  = 1'b0;
    rdy_mode = 0;
    drain();

    // Clock-enable stall during the scan.
    issue(128'h1, 1'b0, 3);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ce0 i_ready", int'(i_ready), 0);
      chk("ce0 o_valid", int'(o_valid), 0);
      step();
    end
    ce = 1'b1;
    drain();

    // Reset mid-scan discards the operation.
    issue(128'h1, 1'b0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("rst o_valid", int'(o_valid), 0);
    chk("rst o_cnt", int'(o_cnt), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst i_ready", int'(i_ready), 1);
    repeat (10) @(negedge clk);

    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] r;
      logic ones;
      int s;
      s    = $urandom_range(0, W);
      r    = rnd_w() >> s;
      ones = 1'($urandom_range(0, 1));
      issue(ones ? ~r : r, ones, 0);
      repeat ($urandom_range(0, 2)) step();
    end
    rdy_mode = 0;
    drain();
    chk("scoreboard empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cntlz_seq.md
Name: cntlz_seq

Overview:
- Multi-cycle leading-zero/leading-one counter for wide operands (default 128 bits).
- Scans the operand 32 bits per cycle, most-significant chunk first, through one 32-bit leading-zero count stage, and stops at the first chunk containing a set bit.
- Replaces a fully combinational wide counter where area matters more than latency.
- Valid/ready handshake on both input and result sides; sits between the operand register file and the normalize/shift logic.

Parameters:
- W, 128: operand width; multiple of 32, range 32..256.
- CW, $clog2(W)+1: result width (8 for W=128); derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ce  in  1  clock enable; when low, all state holds.
- i_valid  in  1  request valid.
- i_ready  out  1  request accepted when i_valid & i_ready.
- i_data  in  W  operand.
- i_ones  in  1  1 = count leading ones, 0 = count leading zeros.
- o_valid  out  1  result valid.
- o_ready  in  1  result consumed when o_valid & o_ready.
- o_cnt  out  CW  count, range 0..W.
- busy  out  1  state != IDLE.

Behaviour:
- NCH = W/32 chunks. Registers:
  - sreg[W-1:0]: working operand.
  - acc[CW-1:0]: running count.
  - idx: chunk index, 0..NCH-1.
  - state: IDLE / SCAN / DONE.
- Reset (rst=1 at a clk edge, regardless of ce): state=IDLE, acc=0, idx=0, sreg=0.
  - Outputs after reset: o_cnt=0, o_valid=0, i_ready=1 when ce=1, busy=0.
  - Reset mid-SCAN or mid-DONE discards the operation; no result is produced.
- i_ready = (state==IDLE) & ce.
- o_valid = (state==DONE) & ce.
- o_cnt = acc. It is stable for the whole time state==DONE.
- IDLE: on i_valid & i_ready:
  - sreg = i_ones ? ~i_data : i_data.
  - acc=0, idx=0, state goes to SCAN.
  - If no request, hold.
- SCAN (ce=1): z = leading-zero count (0..32) of sreg[W-1:W-32].
  - If z<32: acc = acc+z; state goes to DONE.
  - Else if idx==NCH-1: acc = acc+32 (total W); state goes to DONE.
  - Else: acc = acc+32; sreg = sreg<<32 with zero fill; idx = idx+1; stay in SCAN.
- Arithmetic is CW bits wide. The maximum is exactly W, so it never overflows.
- DONE: on o_valid & o_ready, state goes to IDLE. Otherwise hold, with o_cnt unchanged.
- A new request is never accepted in the same cycle a result is consumed. i_ready rises the cycle after the transfer.
- Latency: if the first set (or, in ones mode, first clear) bit lies in chunk k (k=0 is the MS chunk), o_valid rises k+1 cycles after the accept edge.
  - All-zero operand (all-ones in ones mode): NCH cycles, o_cnt=W.
  - Throughput: one result per latency+2 cycles at best.
- ce=0: no register changes except reset; i_ready=0 and o_valid=0, so no handshake can complete. Scanning resumes unchanged when ce returns.
- i_data and i_ones are sampled only at the accept edge. Changes during SCAN/DONE have no effect.
- busy = 1 from the cycle after accept until the cycle after the result transfer.

Test Plan:
- W=128, i_ones=0, i_data=128'h1, o_ready=1 -> o_valid 4 cycles after accept, o_cnt=127, then i_ready=1 next cycle.
- i_data=128'h8000_0000_0000_0000_0000_0000_0000_0000, i_ones=0 -> o_valid 1 cycle after accept, o_cnt=0.
- Two cases, each with o_valid after 4 cycles:
  - i_data=0, i_ones=0 -> o_cnt=128.
  - i_data=all ones, i_ones=1 -> o_cnt=128.
- i_data=128'hFFFF_FFFF_FFF0_0000_0000_0000_0000_0000, i_ones=1 -> o_cnt=44 after 2 cycles. The same data with i_ones=0 -> o_cnt=0 after 1 cycle.
- i_data=128'h0000_0000_0000_0000_0010_0000_0000_0000 -> o_cnt=75 after 3 cycles. Hold o_ready=0 for 5 cycles while toggling i_valid and i_data -> o_valid stays 1, o_cnt stays 75, i_ready stays 0, no new accept.
- Two control cases:
  - Drop ce for 3 cycles during SCAN of 128'h1 -> result is still 127, delivered 3 cycles later.
  - Assert rst during SCAN -> next cycle state is IDLE, o_valid=0, o_cnt=0, busy=0, and no stale result appears.
